// File: rtl/lane_drain_pkg.sv
// Shared types and derived widths for the shortint lane drain block.
package lane_drain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One lane of the source array, as produced by the generator stage.
    typedef shortint lane_t;

    localparam int N_LANES_DEF = 4;
    localparam int W_DEF       = 16;

    // Lane index runs 1..N_LANES, so one extra bit beyond log2 is needed.
    localparam int IDX_W = $clog2(N_LANES_DEF) + 1;
    // Summing N_LANES signed lanes grows by log2(N_LANES) bits, never overflowing.
    localparam int SUM_W = W_DEF + $clog2(N_LANES_DEF);

endpackage

// File: rtl/shortint_lane_drain_if.sv
// Load/stream/status bundle between the lane drain and its neighbours.
interface shortint_lane_drain_if #(
    parameter int N_LANES = 4,
    parameter int W       = 16
);
    localparam int IDX_BITS = $clog2(N_LANES) + 1;
    localparam int SUM_BITS = W + $clog2(N_LANES);

    logic                       load;
    shortint                    lanes_in [1:N_LANES];
    logic                       busy;
    logic                       out_valid;
    logic                       out_ready;
    logic signed [W-1:0]        out_data;
    logic [IDX_BITS-1:0]        out_idx;
    logic                       out_last;
    logic signed [SUM_BITS-1:0] sum_out;
    logic                       sum_valid;
    logic                       err_overrun;

    // Drain side: takes the load, drives the lane stream and the sum.
    modport master (
        input  load, lanes_in, out_ready,
        output busy, out_valid, out_data, out_idx, out_last,
               sum_out, sum_valid, err_overrun
    );

    // Producer/consumer side.
    modport slave (
        output load, lanes_in, out_ready,
        input  busy, out_valid, out_data, out_idx, out_last,
               sum_out, sum_valid, err_overrun
    );

endinterface

// File: rtl/lane_sum_acc.sv
// Signed running-sum accumulator with clear and add-enable.
module lane_sum_acc #(
    parameter int W     = 16,
    parameter int SUM_W = 18
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    add,
    input  logic signed [W-1:0]     lane,
    output logic signed [SUM_W-1:0] sum_next
);

    logic signed [SUM_W-1:0] acc_r;
    logic signed [SUM_W-1:0] lane_ext_s;
    logic signed [SUM_W-1:0] acc_nxt_s;

    // Sign-extend the lane and form the total that would include it.
    always_comb begin
        lane_ext_s = {{(SUM_W-W){lane[W-1]}}, lane};
        sum_next   = acc_r + lane_ext_s;
        if (clr) begin
            acc_nxt_s = '0;
        end else if (add) begin
            acc_nxt_s = sum_next;
        end else begin
            acc_nxt_s = acc_r;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= '0;
        end else begin
            acc_r <= acc_nxt_s;
        end
    end

endmodule

// File: rtl/shortint_lane_drain.sv
// Captures a shortint lane array on load and drains it one lane per cycle,
// lowest index first, then pulses the signed sum of all lanes.
module shortint_lane_drain
    import lane_drain_pkg::*;
#(
    parameter int N_LANES = 4,
    parameter int W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    shortint_lane_drain_if.master bus
);

    localparam int IDX_BITS = $clog2(N_LANES) + 1;
    localparam int SUM_BITS = W + $clog2(N_LANES);
    localparam logic [IDX_BITS-1:0] IDX_FIRST = IDX_BITS'(1);
    localparam logic [IDX_BITS-1:0] IDX_LAST  = IDX_BITS'(N_LANES);

    state_t                     state_r;
    logic signed [W-1:0]        hold_r [1:N_LANES];
    logic                       busy_r;
    logic                       out_valid_r;
    logic signed [W-1:0]        out_data_r;
    logic [IDX_BITS-1:0]        out_idx_r;
    logic                       out_last_r;
    logic signed [SUM_BITS-1:0] sum_out_r;
    logic                       sum_valid_r;
    logic                       err_overrun_r;

    logic                       start_s;
    logic                       beat_s;
    logic [IDX_BITS-1:0]        idx_nxt_s;
    logic signed [SUM_BITS-1:0] sum_next_s;

    // A load is taken in IDLE or DONE; a beat is a handshake while draining.
    // out_valid is high for the whole of DRAIN, so the beat is just out_ready there.
    always_comb begin
        start_s   = 1'b0;
        beat_s    = 1'b0;
        idx_nxt_s = out_idx_r + IDX_FIRST;
        if ((state_r == IDLE) || (state_r == DONE)) begin
            start_s = bus.load;
        end else begin
            start_s = 1'b0;
        end
        if (state_r == DRAIN) begin
            beat_s = bus.out_ready;
        end else begin
            beat_s = 1'b0;
        end
    end

    lane_sum_acc #(
        .W     (W),
        .SUM_W (SUM_BITS)
    ) u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (start_s),
        .add      (beat_s),
        .lane     (out_data_r),
        .sum_next (sum_next_s)
    );

    // Control FSM with registered stream, sum and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            for (int i = 1; i <= N_LANES; i++) begin
                hold_r[i] <= '0;
            end
            busy_r        <= 1'b0;
            out_valid_r   <= 1'b0;
            out_data_r    <= '0;
            out_idx_r     <= IDX_FIRST;
            out_last_r    <= 1'b0;
            sum_out_r     <= '0;
            sum_valid_r   <= 1'b0;
            err_overrun_r <= 1'b0;
        end else begin
            sum_valid_r <= 1'b0;
            if (start_s) begin
                for (int i = 1; i <= N_LANES; i++) begin
                    hold_r[i] <= W'(bus.lanes_in[i]);
                end
                out_data_r    <= W'(bus.lanes_in[1]);
                out_idx_r     <= IDX_FIRST;
                out_last_r    <= (N_LANES == 1);
                out_valid_r   <= 1'b1;
                busy_r        <= 1'b1;
                err_overrun_r <= 1'b0;
                state_r       <= DRAIN;
            end else begin
                case (state_r)
                    IDLE: begin
                        busy_r <= 1'b0;
                    end
                    DRAIN: begin
                        // A load here would clobber lanes still being drained.
                        if (bus.load) begin
                            err_overrun_r <= 1'b1;
                        end
                        if (beat_s) begin
                            if (out_idx_r == IDX_LAST) begin
                                out_valid_r <= 1'b0;
                                out_last_r  <= 1'b0;
                                sum_out_r   <= sum_next_s;
                                sum_valid_r <= 1'b1;
                                state_r     <= DONE;
                            end else begin
                                out_idx_r  <= idx_nxt_s;
                                out_data_r <= hold_r[idx_nxt_s];
                                out_last_r <= (idx_nxt_s == IDX_LAST);
                            end
                        end
                    end
                    DONE: begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                    default: begin
                        busy_r      <= 1'b0;
                        out_valid_r <= 1'b0;
                        out_last_r  <= 1'b0;
                        state_r     <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.busy        = busy_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_data    = out_data_r;
    assign bus.out_idx     = out_idx_r;
    assign bus.out_last    = out_last_r;
    assign bus.sum_out     = sum_out_r;
    assign bus.sum_valid   = sum_valid_r;
    assign bus.err_overrun = err_overrun_r;

endmodule
